fixed_mul_arbiter: RTL
======================

FIXED_MUL_ARBITER -- requirements
Module: fixed_mul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing the multiplier, range 2..8.
REQ-002 SHALL have parameter fractional_size, default 12: fractional bits of the operands.
REQ-003 SHALL have parameter operand_size, default 16: operand width in bits.
REQ-004 SHALL have parameter expansion_size, default operand_size: extra result bits; result width RW = operand_size+expansion_size.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port i_req_valid, input, N_REQ: per-requester operand valid.
REQ-008 SHALL have port i_req_a, input, N_REQ x operand_size, signed: per-requester operand a.
REQ-009 SHALL have port i_req_b, input, N_REQ x operand_size, signed: per-requester operand b.
REQ-010 SHALL have port o_req_ready, output, N_REQ: one-hot grant; handshake on valid&ready.
REQ-011 SHALL have port o_res_valid, output, N_REQ: one-hot result strobe naming the owner of o_res.
REQ-012 SHALL have port o_res, output, RW, signed: shared product bus, (a*b)>>>fractional_size.
REQ-013 SHALL have port o_busy, output, 1: high while any accepted product is still in the pipeline.

Function
REQ-014 SHALL grant round-robin: o_req_ready = one-hot of the first asserted i_req_valid at or after pointer ptr, scanning upward and wrapping from N_REQ-1 to 0.
REQ-015 SHALL assert no o_req_ready bit when i_req_valid is all zero.
REQ-016 SHALL make o_req_ready a combinational function of i_req_valid and ptr only, never of the operand values.
REQ-017 SHALL update ptr to (granted index+1) mod N_REQ on each handshake; SHALL keep ptr unchanged when no handshake occurs.
REQ-018 SHALL accept at most one request per cycle, giving a sustained throughput of one product per cycle.
REQ-019 SHALL register operands and owner index in stage 1 on handshake at edge E.
REQ-020 SHALL compute the product from stage-1 registers and register it in stage 2 at edge E+1.
REQ-021 SHALL drive o_res and o_res_valid from stage 2, so the result is visible for exactly one cycle after edge E+1 (latency 2).
REQ-022 SHALL hold o_res at its last value and o_res_valid at 0 when no result is strobed.
REQ-023 SHALL use full signed precision: sign-extend both operands to operand_size+max(expansion_size,fractional_size) bits, multiply, arithmetic-shift right by fractional_size, and truncate to RW.
REQ-024 SHALL provide no output backpressure; consumers must capture on o_res_valid.
REQ-025 SHALL accept as a legal requester a requester that drops valid before being granted; the block SHALL NOT retain any state for it.
REQ-026 SHALL assert o_busy when either stage holds a valid entry.

Reset
REQ-027 SHALL, while rst is high, asynchronously force ptr=0, both stage valids=0, o_res_valid=0, o_res=0 and o_busy=0; o_req_ready then follows REQ-014 with ptr=0.
REQ-028 SHALL discard any in-flight product on reset mid-operation; no o_res_valid SHALL be emitted for it after rst deasserts.
REQ-029 SHALL allow a handshake in the first cycle after rst deasserts.

Structure
REQ-030 SHALL define the requester-index type (clog2(N_REQ) bits) and the result-width constant in the shared fixed-point package.
REQ-031 SHALL instantiate exactly one fixed_multiply sub-module between stage 1 and stage 2 as the shared multiplier datapath.
REQ-032 SHALL place no arithmetic outside that instance.

Verification
REQ-033 SHALL cover single request: req0 a=0x1000, b=0x1000 (1.0*1.0) -> o_res_valid=0001 two cycles later, o_res=0x00001000.
REQ-034 SHALL cover signed product: req2 a=0xF000 (-1.0), b=0x0800 (0.5) -> o_res_valid=0100, o_res=0xFFFFF800.
REQ-035 SHALL cover full contention: all four requesters valid from reset -> grants 0,1,2,3 on consecutive cycles, then results for 0,1,2,3 on consecutive cycles starting two cycles after the first grant.
REQ-036 SHALL cover fairness: req1 and req3 held valid continuously -> grants alternate 1,3,1,3 and neither is starved.
REQ-037 SHALL cover reset mid-flight: two products accepted, rst pulsed one cycle later -> no o_res_valid afterwards, o_res=0, ptr=0, and the next grant goes to the lowest valid index.
REQ-038 SHALL cover idle: no valids for 10 cycles -> o_req_ready=0, o_busy=0, ptr unchanged, o_res unchanged.

Source files
------------

// File: rtl/fixed_mul_arbiter_pkg.sv
// Shared fixed-point definitions for the arbitrated multiplier: width helpers,
// requester-index type and result-width constant for the default build.
package fixed_mul_arbiter_pkg;

  localparam int unsigned N_REQ_DEFAULT     = 4;
  localparam int unsigned OPERAND_W_DEFAULT = 16;
  localparam int unsigned REQ_IDX_W_DEFAULT = $clog2(N_REQ_DEFAULT);
  localparam int unsigned RES_W_DEFAULT     = 2 * OPERAND_W_DEFAULT;

  typedef logic [REQ_IDX_W_DEFAULT-1:0] req_idx_t;

  // Bits needed to name one of n requesters (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of the shared result bus.
  function automatic int unsigned res_width(input int unsigned op_w, input int unsigned exp_w);
    return op_w + exp_w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fixed_mul_arbiter_multiply.sv
// Signed fixed-point multiply: sign-extend, multiply, arithmetic shift by the
// fractional width, truncate to the result width. Purely combinational.
module fixed_multiply
  import fixed_mul_arbiter_pkg::*;
#(
  parameter int unsigned operand_size    = 16,
  parameter int unsigned fractional_size = 12,
  parameter int unsigned expansion_size  = operand_size
) (
  input  logic signed [operand_size-1:0]                                a_i,
  input  logic signed [operand_size-1:0]                                b_i,
  output logic signed [res_width(operand_size, expansion_size)-1:0]     p_o
);

  localparam int unsigned EW = operand_size + max_u(expansion_size, fractional_size);
  localparam int unsigned RW = res_width(operand_size, expansion_size);

  logic signed [EW-1:0] a_ext;
  logic signed [EW-1:0] b_ext;
  logic signed [EW-1:0] prod;
  logic signed [EW-1:0] shifted;

  // Extended-precision product rescaled back to the fixed-point grid.
  always_comb begin
    a_ext   = EW'(a_i);
    b_ext   = EW'(b_i);
    prod    = a_ext * b_ext;
    shifted = prod >>> fractional_size;
    p_o     = shifted[RW-1:0];
  end

endmodule

// File: rtl/fixed_mul_arbiter.sv
// Round-robin arbiter in front of one shared two-stage signed fixed-point
// multiplier. One grant per cycle, results strobed to their owner two edges later.
module fixed_mul_arbiter
  import fixed_mul_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned fractional_size = 12,
  parameter int unsigned operand_size    = 16,
  parameter int unsigned expansion_size  = operand_size
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [N_REQ-1:0]                                         i_req_valid,
  input  logic signed [N_REQ-1:0][operand_size-1:0]                i_req_a,
  input  logic signed [N_REQ-1:0][operand_size-1:0]                i_req_b,
  output logic [N_REQ-1:0]                                         o_req_ready,
  output logic [N_REQ-1:0]                                         o_res_valid,
  output logic signed [res_width(operand_size, expansion_size)-1:0] o_res,
  output logic                                                     o_busy
);

  localparam int unsigned IW = idx_width(N_REQ);
  localparam int unsigned RW = res_width(operand_size, expansion_size);

  logic [IW-1:0]            ptr_q;
  logic [IW-1:0]            ptr_d;
  logic [IW-1:0]            gnt_idx;
  logic [N_REQ-1:0]         gnt;
  logic                     hs;

  logic                     vld_p1_q;
  logic [IW-1:0]            idx_p1_q;
  logic signed [operand_size-1:0] a_p1_q;
  logic signed [operand_size-1:0] b_p1_q;

  logic signed [RW-1:0]     mul_p;

  logic                     vld_p2_q;
  logic [IW-1:0]            idx_p2_q;
  logic signed [RW-1:0]     res_p2_q;

  // Round-robin pick: first valid at or above ptr, else first valid below it.
  // Depends on valids and ptr only, so grants never see operand values.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    ptr_d   = ptr_q;
    hs      = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!hs && i_req_valid[i] && (i >= int'(ptr_q))) begin
        hs      = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
        ptr_d   = (i == int'(N_REQ) - 1) ? '0 : IW'(i + 1);
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!hs && i_req_valid[i] && (i < int'(ptr_q))) begin
        hs      = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
        ptr_d   = (i == int'(N_REQ) - 1) ? '0 : IW'(i + 1);
      end
    end
  end

  assign o_req_ready = gnt;

  // Pointer advances past the winner on every handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // ---- stage 1: capture granted operands and owner ----
  // Stage-1 valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= hs;
  end

  // Stage-1 operand and owner capture, only on a handshake.
  always_ff @(posedge clk) begin
    if (hs) begin
      a_p1_q   <= i_req_a[gnt_idx];
      b_p1_q   <= i_req_b[gnt_idx];
      idx_p1_q <= gnt_idx;
    end
  end

  fixed_multiply #(
    .operand_size    (operand_size),
    .fractional_size (fractional_size),
    .expansion_size  (expansion_size)
  ) u_mul (
    .a_i (a_p1_q),
    .b_i (b_p1_q),
    .p_o (mul_p)
  );

  // ---- stage 2: registered product drives the shared result bus ----
  // Stage-2 valid and result; result holds when nothing new arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) res_p2_q <= mul_p;
    end
  end

  // Stage-2 owner index follows the product.
  always_ff @(posedge clk) begin
    if (vld_p1_q) idx_p2_q <= idx_p1_q;
  end

  // One-hot result strobe naming the owner of o_res.
  always_comb begin
    o_res_valid = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      o_res_valid[i] = vld_p2_q && (idx_p2_q == IW'(i));
    end
  end

  assign o_res  = res_p2_q;
  assign o_busy = vld_p1_q | vld_p2_q;

endmodule
